stack_alu_seq: RTL and testbench
================================

Name: stack_alu_seq

Overview:
- Clocked, parametrised stack-machine ALU: the successor of our combinational stack ALU.
- Holds a DEPTH-entry signed operand stack in registers.
- Executes one opcode per accepted command over a valid/ready handshake.
- Arithmetic consumes the top two entries and pushes the result back.
- Multiply is a multi-cycle shift-add unit.
- Stack over/underflow is reported separately from arithmetic overflow.

Parameters:
- N, 8, data width in bits (signed two's complement).
- DEPTH, 16, number of stack entries; must be >= 2.
- CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  block can accept a command this cycle.
- opcode  in  3  000 NOP, 001 DUP, 010 SWAP, 011 SUB, 100 ADD, 101 MUL, 110 PUSH, 111 POP.
- data_in  in  N  PUSH operand; ignored for other opcodes.
- out_valid  out  1  one-cycle pulse; result, flags and status are valid.
- out_data  out  N  result, or the popped value.
- overflow  out  1  signed arithmetic overflow of the reported result.
- stk_err  out  1  stack underflow or full; the command was not executed.
- depth  out  CNT_W  current occupancy, 0..DEPTH.

Behaviour:
- Reset:
  - depth=0, in_ready=1, out_valid=0, out_data=0, overflow=0, stk_err=0.
  - FSM goes to IDLE.
  - Stack contents are don't-care.
- Accept rule: a command is accepted when in_valid && in_ready on a rising edge. Commands are not queued.
- Naming: T = top entry, S = entry below T.
- Outputs report once, then hold:
  - out_valid pulses exactly once per accepted command, NOP included.
  - out_data, overflow and stk_err hold their values until the next pulse.
- Single-cycle opcodes (out_valid is high in the cycle after accept; in_ready stays 1):
  - PUSH: requires depth<DEPTH. data_in becomes T; depth+1; out_data=data_in.
  - POP: requires depth>=1. out_data=T; depth-1.
  - DUP: requires 1<=depth<DEPTH. Pushes a copy of T; out_data=T.
  - SWAP: requires depth>=2. Exchanges T and S; out_data=new T.
  - ADD: requires depth>=2. r=S+T. S and T are replaced by r; depth-1; out_data=r.
  - SUB: requires depth>=2. r=S-T, with the same replacement as ADD.
  - NOP: out_data unchanged, overflow=0, stk_err=0.
- Overflow for ADD and SUB:
  - r is the low N bits of the result (wraps).
  - overflow=1 if and only if the exact result is outside [-2^(N-1), 2^(N-1)-1].
  - overflow=0 for PUSH, POP, DUP, SWAP and NOP.
- MUL: requires depth>=2. FSM states are IDLE, MUL_RUN and MUL_DONE.
  - On accept: latch S and T, go to MUL_RUN, in_ready=0.
  - MUL_RUN: one shift-add step per cycle for N cycles, on magnitudes, with sign correction.
  - MUL_DONE: the full 2N-bit signed product P is complete. Write the low N bits over S/T; depth-1.
  - overflow=1 if and only if P differs from the sign-extension of its low N bits.
  - out_valid is high in MUL_DONE, then return to IDLE with in_ready=1.
  - Latency: out_valid exactly N+1 cycles after the accept edge.
  - Stack, depth and FSM state are not otherwise modified during MUL.
- Stack errors (requirement not met):
  - No stack or depth change.
  - out_valid=1 the next cycle, stk_err=1, overflow=0, out_data keeps its previous value.
  - A MUL that fails its depth check does not enter MUL_RUN.
- Boundaries:
  - PUSH at depth==DEPTH is an error.
  - POP, arithmetic or SWAP with insufficient entries is an error.
  - Depth never wraps.
- Back-to-back: single-cycle commands may be accepted every cycle. Each command sees the stack state left by the previous one.
- Reset mid-operation: rst has priority over everything.
  - A MUL in progress is abandoned with no result pulse.
  - All outputs return to reset values on the next edge.
- in_valid while in_ready=0 is ignored; the driver must hold the command.

Test Plan (N=8, DEPTH=16):
- PUSH 100, PUSH 50, ADD -> out_data=-106 (0x96), overflow=1, depth=1. Then PUSH 6, SUB -> out_data=-112, overflow=0.
- PUSH -3, PUSH 7, MUL -> in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept; out_data=-21, overflow=0, depth=1.
- PUSH 16, PUSH 16, MUL -> out_data=0x00, overflow=1. PUSH -128, PUSH 1, MUL -> out_data=-128, overflow=0.
- From reset: POP -> stk_err=1, depth=0, out_data=0. PUSH 5, ADD -> stk_err=1, depth stays 1. SWAP with depth 1 -> stk_err=1.
- PUSH 1..16 -> depth=16, no errors. PUSH 17 -> stk_err=1, depth=16. POP -> out_data=16. DUP twice -> second DUP gives stk_err=1, depth=16.
- Assert rst 3 cycles into a MUL -> no out_valid pulse; depth=0, in_ready=1 after the reset edge. A following PUSH 9 then POP -> out_data=9.

Source files
------------

// File: rtl/stack_alu_seq.sv
// stack_alu_seq: clocked stack-machine ALU with a register stack and a multi-cycle shift-add multiplier
module stack_alu_seq #(
   parameter int N     = 8,
   parameter int DEPTH = 16,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [N-1:0]     data_in,
   output logic             out_valid,
   output logic [N-1:0]     out_data,
   output logic             overflow,
   output logic             stk_err,
   output logic [CNT_W-1:0] depth
);
   localparam int IW = $clog2(DEPTH);
   localparam int SW = $clog2(N + 1);
   localparam logic [2:0] OP_NOP = 3'b000, OP_DUP = 3'b001, OP_SWAP = 3'b010, OP_SUB = 3'b011,
                          OP_ADD = 3'b100, OP_MUL = 3'b101, OP_PUSH = 3'b110, OP_POP = 3'b111;
   typedef enum logic [1:0] {IDLE, MUL_RUN, MUL_DONE} state_t;
   state_t state, state_nx;
   logic [N-1:0] stk [DEPTH];
   logic [IW-1:0] ti, si, pi;
   logic [N-1:0] t, s, abs_s, abs_t;
   logic [N:0] add_r, sub_r;
   logic [2*N-1:0] mcand, acc, acc_nx, prod;
   logic [N-1:0] mplier;
   logic [SW-1:0] step;
   logic neg, accept, err, full, ge1, ge2, last, report;
   assign in_ready = state != MUL_RUN;
   assign accept   = in_valid && in_ready;
   assign ti    = IW'(depth - CNT_W'(1));
   assign si    = IW'(depth - CNT_W'(2));
   assign pi    = IW'(depth);
   assign t     = stk[ti];
   assign s     = stk[si];
   assign full  = depth == CNT_W'(DEPTH);
   assign ge1   = depth != '0;
   assign ge2   = depth >= CNT_W'(2);
   assign abs_s = s[N-1] ? -s : s;
   assign abs_t = t[N-1] ? -t : t;
   assign add_r = {s[N-1], s} + {t[N-1], t};
   assign sub_r = {s[N-1], s} - {t[N-1], t};
   assign acc_nx = acc + (mplier[0] ? mcand : '0);
   assign prod   = neg ? -acc_nx : acc_nx;
   assign last   = step == SW'(N - 1);
   // A MUL that passes its depth check stays silent until the product is written back
   assign report = opcode != OP_MUL || err;
   always_comb begin
      err = (opcode == OP_PUSH) ? full :
            (opcode == OP_POP)  ? !ge1 :
            (opcode == OP_DUP)  ? (!ge1 || full) :
            (opcode == OP_NOP)  ? 1'b0 : !ge2;
      state_nx = (state == MUL_RUN) ? (last ? MUL_DONE : MUL_RUN) :
                 (accept && opcode == OP_MUL && !err) ? MUL_RUN : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         depth     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         overflow  <= 1'b0;
         stk_err   <= 1'b0;
         step      <= '0;
      end else begin
         state     <= state_nx;
         out_valid <= 1'b0;
         if (state == MUL_RUN) begin
            acc    <= acc_nx;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            step   <= step + SW'(1);
            if (last) begin
               stk[si]   <= prod[N-1:0];
               depth     <= depth - CNT_W'(1);
               out_valid <= 1'b1;
               out_data  <= prod[N-1:0];
               overflow  <= prod[2*N-1:N] != {N{prod[N-1]}};
               stk_err   <= 1'b0;
            end
         end else if (accept) begin
            if (report) begin
               out_valid <= 1'b1;
               stk_err   <= err;
               overflow  <= 1'b0;
            end
            if (!err) begin
               case (opcode)
                  OP_PUSH: begin
                     stk[pi]  <= data_in;
                     depth    <= depth + CNT_W'(1);
                     out_data <= data_in;
                  end
                  OP_POP: begin
                     depth    <= depth - CNT_W'(1);
                     out_data <= t;
                  end
                  OP_DUP: begin
                     stk[pi]  <= t;
                     depth    <= depth + CNT_W'(1);
                     out_data <= t;
                  end
                  OP_SWAP: begin
                     stk[ti]  <= s;
                     stk[si]  <= t;
                     out_data <= s;
                  end
                  OP_ADD: begin
                     stk[si]  <= add_r[N-1:0];
                     depth    <= depth - CNT_W'(1);
                     out_data <= add_r[N-1:0];
                     overflow <= add_r[N] ^ add_r[N-1];
                  end
                  OP_SUB: begin
                     stk[si]  <= sub_r[N-1:0];
                     depth    <= depth - CNT_W'(1);
                     out_data <= sub_r[N-1:0];
                     overflow <= sub_r[N] ^ sub_r[N-1];
                  end
                  OP_MUL: begin
                     acc    <= '0;
                     mcand  <= {{N{1'b0}}, abs_s};
                     mplier <= abs_t;
                     neg    <= s[N-1] ^ t[N-1];
                     step   <= '0;
                  end
                  default: ;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_stack_alu_seq.sv
// tb_stack_alu_seq: directed and random commands checked against a queue-based stack model
module tb_stack_alu_seq;
   localparam int N = 8;
   localparam int DEPTH = 16;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [2:0] NOP = 3'b000, DUP = 3'b001, SWAP = 3'b010, SUB = 3'b011,
                          ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;
   logic clk = 0, rst = 1, in_valid = 0, in_ready, out_valid, overflow, stk_err;
   logic [2:0] opcode = NOP;
   logic [N-1:0] data_in = '0, out_data;
   logic [CNT_W-1:0] depth;
   int vectors = 0, miscompares = 0;
   int model[$];
   int last_out = 0;
   stack_alu_seq #(.N(N), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
      .data_in(data_in), .out_valid(out_valid), .out_data(out_data), .overflow(overflow),
      .stk_err(stk_err), .depth(depth)
   );
   always #5 clk = ~clk;
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   function automatic int wrap(input int x);
      logic signed [N-1:0] v;
      v = x[N-1:0];
      return int'(v);
   endfunction
   // Issue one command, wait for its pulse, and compare against the model's prediction
   task automatic send(input logic [2:0] op, input int d);
      int n, s, t, ex, r, exp_d, exp_lat, cycles, busy;
      bit exp_err, exp_ovf;
      n = model.size();
      exp_err = 0; exp_ovf = 0; exp_lat = 1; exp_d = last_out;
      case (op)
         PUSH: if (n == DEPTH) exp_err = 1; else begin exp_d = wrap(d); model.push_back(exp_d); end
         POP:  if (n < 1) exp_err = 1; else exp_d = model.pop_back();
         DUP:  if (n < 1 || n == DEPTH) exp_err = 1; else begin exp_d = model[n-1]; model.push_back(exp_d); end
         SWAP: if (n < 2) exp_err = 1;
               else begin t = model.pop_back(); s = model.pop_back(); model.push_back(t); model.push_back(s); exp_d = s; end
         ADD, SUB, MUL: if (n < 2) exp_err = 1;
               else begin
                  t = model.pop_back(); s = model.pop_back();
                  ex = (op == ADD) ? s + t : (op == SUB) ? s - t : s * t;
                  r = wrap(ex);
                  exp_ovf = ex != r;
                  exp_d = r;
                  model.push_back(r);
                  if (op == MUL) exp_lat = N + 1;
               end
         default: ;
      endcase
      last_out = exp_d;
      @(negedge clk);
      in_valid = 1; opcode = op; data_in = d[N-1:0];
      @(posedge clk);
      #1 in_valid = 0;
      cycles = 1; busy = 0;
      while (!out_valid && cycles < 3 * N) begin
         busy += !in_ready;
         @(posedge clk);
         #1 cycles++;
      end
      check("latency", cycles, exp_lat);
      check("busy_cycles", busy, exp_lat - 1);
      check("out_data", $signed(out_data), exp_d);
      check("overflow", overflow, exp_ovf);
      check("stk_err", stk_err, exp_err);
      check("depth", depth, model.size());
   endtask
   task automatic drain();
      while (model.size() > 0) send(POP, 0);
   endtask
   initial begin
      int pulses;
      repeat (3) @(posedge clk);
      #1;
      check("rst_depth", depth, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_overflow", overflow, 0);
      check("rst_stk_err", stk_err, 0);
      @(negedge clk) rst = 0;
      send(POP, 0);
      send(PUSH, 5);
      send(ADD, 0);
      check("add_underflow_depth", depth, 1);
      send(SWAP, 0);
      check("swap_underflow_err", stk_err, 1);
      drain();
      send(PUSH, 100);
      send(PUSH, 50);
      send(ADD, 0);
      check("add_wrap_value", $signed(out_data), -106);
      check("add_wrap_ovf", overflow, 1);
      send(PUSH, 6);
      send(SUB, 0);
      check("sub_value", $signed(out_data), -112);
      drain();
      send(PUSH, -3);
      send(PUSH, 7);
      send(MUL, 0);
      check("mul_neg_value", $signed(out_data), -21);
      drain();
      send(PUSH, 16);
      send(PUSH, 16);
      send(MUL, 0);
      check("mul_ovf_value", out_data, 0);
      check("mul_ovf_flag", overflow, 1);
      send(PUSH, -128);
      send(PUSH, 1);
      send(MUL, 0);
      check("mul_min_value", $signed(out_data), -128);
      drain();
      send(NOP, 0);
      for (int i = 1; i <= 16; i++) send(PUSH, i);
      check("full_depth", depth, 16);
      send(PUSH, 17);
      check("full_push_err", stk_err, 1);
      send(POP, 0);
      check("pop_after_full", out_data, 16);
      send(DUP, 0);
      send(DUP, 0);
      check("dup_full_err", stk_err, 1);
      drain();
      send(PUSH, 11);
      send(PUSH, -4);
      @(negedge clk);
      in_valid = 1; opcode = MUL;
      @(posedge clk);
      #1 in_valid = 0;
      pulses = 0;
      repeat (2) begin @(posedge clk); #1 pulses += out_valid; end
      @(negedge clk) rst = 1;
      @(posedge clk);
      #1;
      check("midmul_rst_depth", depth, 0);
      check("midmul_rst_ready", in_ready, 1);
      check("midmul_rst_valid", out_valid, 0);
      @(negedge clk) rst = 0;
      repeat (12) begin @(posedge clk); #1 pulses += out_valid; end
      check("midmul_no_pulse", pulses, 0);
      model.delete();
      last_out = 0;
      send(PUSH, 9);
      send(POP, 0);
      check("post_rst_pop", out_data, 9);
      for (int i = 0; i < 400; i++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 9) < 4) ? PUSH : 3'($urandom_range(0, 7));
         send(op, int'($urandom_range(0, 255)) - 128);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
